// File: rtl/sqrt_result_collector.sv
// Result collector for a recoded-float sqrt unit: tracks issue-to-result
// latency, converts each result to standard IEEE format and queues
// {data, flags, cycles} in a small FIFO for a ready/valid consumer.

// Recoded (HardFloat) to standard IEEE format conversion.
module recFNToFN #(
    parameter int EXP_WIDTH = 8,
    parameter int SIG_WIDTH = 24
) (
    input  logic [EXP_WIDTH+SIG_WIDTH:0]   i_rec,
    output logic [EXP_WIDTH+SIG_WIDTH-1:0] o_fn
);
    localparam int DW = $clog2(SIG_WIDTH);
    // Smallest recoded exponent that still maps to a normal number.
    localparam logic [EXP_WIDTH:0] MIN_NORM = (EXP_WIDTH+1)'((1 << (EXP_WIDTH-1)) + 2);
    localparam logic [EXP_WIDTH:0] ONE      = (EXP_WIDTH+1)'(1);

    logic                 w_sign;
    logic [EXP_WIDTH:0]   w_exp;
    logic [SIG_WIDTH-2:0] w_fract;
    logic                 w_is_zero;
    logic                 w_is_special;
    logic                 w_is_nan;
    logic                 w_is_inf;
    logic                 w_is_sub;
    logic [DW-1:0]        w_dist;
    logic [SIG_WIDTH-2:0] w_den;
    logic [EXP_WIDTH-1:0] w_exp_out;
    logic [SIG_WIDTH-2:0] w_fract_out;

    assign w_sign       = i_rec[EXP_WIDTH+SIG_WIDTH];
    assign w_exp        = i_rec[EXP_WIDTH+SIG_WIDTH-1 -: EXP_WIDTH+1];
    assign w_fract      = i_rec[SIG_WIDTH-2:0];
    // Top three exponent bits zero encode zero; top two ones encode inf/NaN.
    assign w_is_zero    = (w_exp[EXP_WIDTH -: 3] == 3'b000);
    assign w_is_special = (w_exp[EXP_WIDTH -: 2] == 2'b11);
    assign w_is_nan     = w_is_special & w_exp[EXP_WIDTH-2];
    assign w_is_inf     = w_is_special & ~w_exp[EXP_WIDTH-2];
    assign w_is_sub     = (w_exp < MIN_NORM);
    // Subnormals: shift the significand (hidden bit included) right into place.
    assign w_dist       = DW'(MIN_NORM - ONE - w_exp);
    assign w_den        = (SIG_WIDTH-1)'(({~w_is_zero, w_fract} >> 1) >> w_dist);
    assign w_exp_out    = (w_is_sub ? '0 : EXP_WIDTH'(w_exp - MIN_NORM + ONE))
                        | {EXP_WIDTH{w_is_nan | w_is_inf}};
    assign w_fract_out  = w_is_sub ? w_den : (w_is_inf ? '0 : w_fract);
    assign o_fn         = {w_sign, w_exp_out, w_fract_out};
endmodule

module sqrt_result_collector #(
    parameter int EXP_WIDTH = 8,
    parameter int SIG_WIDTH = 24,
    parameter int DEPTH     = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          issue_i,
    input  logic                          res_valid_i,
    input  logic [EXP_WIDTH+SIG_WIDTH:0]  res_rec_i,
    input  logic [4:0]                    res_flags_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [EXP_WIDTH+SIG_WIDTH-1:0] out_data_o,
    output logic [4:0]                    out_flags_o,
    output logic [15:0]                   out_cycles_o,
    output logic [$clog2(DEPTH):0]        count_o,
    output logic                          overflow_o,
    output logic                          proto_err_o
);
    localparam int FW    = EXP_WIDTH + SIG_WIDTH;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int ENT_W = FW + 5 + 16;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t             r_state;
    logic [15:0]        r_cnt;
    logic [AW-1:0]      r_wp;
    logic [AW-1:0]      r_rp;
    logic [CW-1:0]      r_count;
    logic               r_overflow;
    logic               r_proto_err;
    logic [ENT_W-1:0]   r_mem [DEPTH];

    logic [FW-1:0]      w_fn;
    logic [15:0]        w_lat;
    logic [15:0]        w_cyc;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic [ENT_W-1:0]   w_head;

    recFNToFN #(
        .EXP_WIDTH (EXP_WIDTH),
        .SIG_WIDTH (SIG_WIDTH)
    ) u_conv (
        .i_rec (res_rec_i),
        .o_fn  (w_fn)
    );

    // Latency as it will read at the next edge, saturating at all ones.
    assign w_lat  = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
    // A result with no operand in flight carries zero latency.
    assign w_cyc  = (r_state == BUSY) ? w_lat : 16'd0;
    assign w_full = (r_count == CW'(DEPTH));
    assign w_pop  = out_valid_o & out_ready_i;
    // When full, a same-cycle pop frees the slot the push needs.
    assign w_push = res_valid_i & (~w_full | w_pop);

    // Issue/result tracking, latency counter and protocol error flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_cnt       <= 16'd0;
            r_proto_err <= 1'b0;
        end else begin
            if ((issue_i & (r_state == BUSY) & ~res_valid_i) |
                (res_valid_i & (r_state == IDLE)))
                r_proto_err <= 1'b1;
            if (issue_i) begin
                r_state <= BUSY;
                r_cnt   <= 16'd0;
            end else if (res_valid_i) begin
                r_state <= IDLE;
                r_cnt   <= 16'd0;
            end else if (r_state == BUSY) begin
                r_cnt   <= w_lat;
            end
        end
    end

    // FIFO storage; validity is tracked by the pointers, so no reset needed.
    always_ff @(posedge clk_i) begin
        if (w_push)
            r_mem[r_wp] <= {w_fn, res_flags_i, w_cyc};
    end

    // FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push)
                r_wp <= r_wp + AW'(1);
            if (w_pop)
                r_rp <= r_rp + AW'(1);
            if (w_push & ~w_pop)
                r_count <= r_count + CW'(1);
            else if (~w_push & w_pop)
                r_count <= r_count - CW'(1);
            if (res_valid_i & ~w_push)
                r_overflow <= 1'b1;
        end
    end

    // Head is read straight from storage and forced to zero when empty.
    assign w_head       = r_mem[r_rp];
    assign out_valid_o  = (r_count != '0);
    assign out_data_o   = out_valid_o ? w_head[ENT_W-1 -: FW] : '0;
    assign out_flags_o  = out_valid_o ? w_head[20:16] : '0;
    assign out_cycles_o = out_valid_o ? w_head[15:0] : '0;
    assign count_o      = r_count;
    assign overflow_o   = r_overflow;
    assign proto_err_o  = r_proto_err;
endmodule

// File: tb/tb_sqrt_result_collector.sv
// Bench for sqrt_result_collector: vector table of recoded results driven
// through issue/result pairs, scoreboard queue checked on every pop, plus
// directed sequences for overflow, pop-while-full, protocol errors and reset.
module tb_sqrt_result_collector;
    logic        clk = 1'b0;
    logic        rst;
    logic        issue;
    logic        res_valid;
    logic [32:0] res_rec;
    logic [4:0]  res_flags;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_flags;
    logic [15:0] out_cycles;
    logic [2:0]  count;
    logic        overflow;
    logic        proto_err;

    int n_chk = 0;
    int n_err = 0;

    typedef struct packed {
        logic [31:0] d;
        logic [4:0]  f;
        logic [15:0] c;
    } ent_t;
    ent_t sbq[$];

    typedef struct {
        logic [32:0] rec;
        logic [4:0]  flg;
        int          lat;
        logic [31:0] std;
    } vec_t;
    vec_t tbl[8];

    sqrt_result_collector #(.EXP_WIDTH(8), .SIG_WIDTH(24), .DEPTH(4)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .issue_i      (issue),
        .res_valid_i  (res_valid),
        .res_rec_i    (res_rec),
        .res_flags_i  (res_flags),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_data_o   (out_data),
        .out_flags_o  (out_flags),
        .out_cycles_o (out_cycles),
        .count_o      (count),
        .overflow_o   (overflow),
        .proto_err_o  (proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every accepted head is compared against the queue front.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                chk("pop_unexpected", {32'd0, out_data}, 64'hDEAD_BEEF_DEAD_BEEF);
            end else begin
                ent_t e;
                e = sbq.pop_front();
                chk("pop_data", {32'd0, out_data}, {32'd0, e.d});
                chk("pop_flags", {59'd0, out_flags}, {59'd0, e.f});
                chk("pop_cycles", {48'd0, out_cycles}, {48'd0, e.c});
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1; issue = 1'b0; res_valid = 1'b0; out_ready = 1'b0;
        res_rec = '0; res_flags = '0;
        sbq.delete();
        repeat (2) step();
        rst = 1'b0;
        step();
    endtask

    // One issue followed by its result lat cycles later.
    task automatic pair(input logic [32:0] rec, input logic [4:0] flg, input int lat,
                        input logic [31:0] std, input bit accept, input bit rdy_at_res);
        issue = 1'b1;
        step();
        issue = 1'b0;
        repeat (lat - 1) step();
        res_valid = 1'b1; res_rec = rec; res_flags = flg;
        if (rdy_at_res) out_ready = 1'b1;
        if (accept) sbq.push_back({std, flg, 16'(lat)});
        step();
        res_valid = 1'b0;
        if (rdy_at_res) out_ready = 1'b0;
    endtask

    task automatic drain(input int n);
        out_ready = 1'b1;
        repeat (n) step();
        out_ready = 1'b0;
        step();
        chk("drain_count", {61'd0, count}, 64'd0);
        chk("drain_sb_empty", 64'(sbq.size()), 64'd0);
    endtask

    initial begin
        // recoded input, flags, latency, expected standard result
        tbl[0] = '{{1'b0, 9'h100, 23'h000000}, 5'b00001, 5,  32'h3F800000}; // 1.0
        tbl[1] = '{{1'b0, 9'h000, 23'h000000}, 5'b00000, 1,  32'h00000000}; // +0
        tbl[2] = '{{1'b1, 9'h000, 23'h000000}, 5'b00000, 2,  32'h80000000}; // -0
        tbl[3] = '{{1'b0, 9'h180, 23'h000000}, 5'b00000, 3,  32'h7F800000}; // +inf
        tbl[4] = '{{1'b0, 9'h1C0, 23'h400000}, 5'b10000, 7,  32'h7FC00000}; // qNaN
        tbl[5] = '{{1'b0, 9'h081, 23'h000000}, 5'b00010, 4,  32'h00400000}; // subnormal
        tbl[6] = '{{1'b0, 9'h17F, 23'h7FFFFF}, 5'b00001, 12, 32'h7F7FFFFF}; // max normal
        tbl[7] = '{{1'b0, 9'h082, 23'h000000}, 5'b00000, 9,  32'h00800000}; // min normal

        do_reset();
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_count", {61'd0, count}, 64'd0);
        chk("rst_overflow", {63'd0, overflow}, 64'd0);
        chk("rst_proto", {63'd0, proto_err}, 64'd0);
        chk("rst_data", {32'd0, out_data}, 64'd0);

        // sqrt(12.0): issue, result 23 cycles later
        pair({1'b0, 9'h101, 23'h5DB3D7}, 5'b00000, 23, 32'h405DB3D7, 1'b1, 1'b0);
        chk("sqrt12_data", {32'd0, out_data}, 64'h405DB3D7);
        chk("sqrt12_cycles", {48'd0, out_cycles}, 64'd23);
        chk("sqrt12_count", {61'd0, count}, 64'd1);
        chk("sqrt12_valid", {63'd0, out_valid}, 64'd1);
        drain(1);

        // Table vectors with the consumer always ready
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++)
            pair(tbl[i].rec, tbl[i].flg, tbl[i].lat, tbl[i].std, 1'b1, 1'b0);
        repeat (2) step();
        out_ready = 1'b0;
        chk("tbl_count", {61'd0, count}, 64'd0);
        chk("tbl_sb_empty", 64'(sbq.size()), 64'd0);
        chk("tbl_proto", {63'd0, proto_err}, 64'd0);

        // Back-to-back: new issue in the same cycle as the result
        out_ready = 1'b1;
        issue = 1'b1; step(); issue = 1'b0;
        repeat (2) step();
        issue = 1'b1; res_valid = 1'b1; res_rec = tbl[0].rec; res_flags = 5'b00001;
        sbq.push_back({32'h3F800000, 5'b00001, 16'd3});
        step();
        issue = 1'b0; res_valid = 1'b0;
        repeat (4) step();
        res_valid = 1'b1; res_rec = tbl[3].rec; res_flags = 5'b00000;
        sbq.push_back({32'h7F800000, 5'b00000, 16'd5});
        step();
        res_valid = 1'b0;
        repeat (2) step();
        chk("b2b_proto", {63'd0, proto_err}, 64'd0);

        // Issue while busy restarts the counter and flags an error
        issue = 1'b1; step(); issue = 1'b0;
        repeat (3) step();
        issue = 1'b1; step(); issue = 1'b0;
        repeat (5) step();
        res_valid = 1'b1; res_rec = tbl[7].rec; res_flags = 5'b00000;
        sbq.push_back({32'h00800000, 5'b00000, 16'd6});
        step();
        res_valid = 1'b0;
        repeat (2) step();
        out_ready = 1'b0;
        chk("rebusy_proto", {63'd0, proto_err}, 64'd1);
        chk("rebusy_sb_empty", 64'(sbq.size()), 64'd0);

        // Overflow: five results into a four-entry FIFO, nobody reading
        do_reset();
        for (int i = 0; i < 5; i++)
            pair(tbl[i].rec, tbl[i].flg, 3, tbl[i].std, i < 4, 1'b0);
        chk("ovf_count", {61'd0, count}, 64'd4);
        chk("ovf_flag", {63'd0, overflow}, 64'd1);
        drain(4);

        // Full FIFO with a pop in the same cycle as the result
        do_reset();
        chk("rst_clears_ovf", {63'd0, overflow}, 64'd0);
        for (int i = 0; i < 4; i++)
            pair(tbl[i].rec, tbl[i].flg, 2, tbl[i].std, 1'b1, 1'b0);
        pair(tbl[6].rec, tbl[6].flg, 2, tbl[6].std, 1'b1, 1'b1);
        chk("fullpop_count", {61'd0, count}, 64'd4);
        chk("fullpop_ovf", {63'd0, overflow}, 64'd0);
        drain(4);

        // Result with no issue: NaN, invalid flag, zero latency
        do_reset();
        res_valid = 1'b1; res_rec = {1'b0, 9'h1C0, 23'h400000}; res_flags = 5'b10000;
        sbq.push_back({32'h7FC00000, 5'b10000, 16'd0});
        step();
        res_valid = 1'b0;
        chk("orphan_proto", {63'd0, proto_err}, 64'd1);
        chk("orphan_cycles", {48'd0, out_cycles}, 64'd0);
        chk("orphan_flags", {59'd0, out_flags}, 64'h10);
        chk("orphan_data", {32'd0, out_data}, 64'h7FC00000);
        drain(1);

        // Asynchronous reset mid-flight with a non-empty FIFO
        do_reset();
        pair(tbl[6].rec, tbl[6].flg, 4, tbl[6].std, 1'b1, 1'b0);
        issue = 1'b1; step(); issue = 1'b0;
        repeat (10) step();
        #1 rst = 1'b1;
        #1;
        chk("arst_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_count", {61'd0, count}, 64'd0);
        chk("arst_data", {32'd0, out_data}, 64'd0);
        chk("arst_flags", {59'd0, out_flags}, 64'd0);
        chk("arst_cycles", {48'd0, out_cycles}, 64'd0);
        chk("arst_proto", {63'd0, proto_err}, 64'd0);
        sbq.delete();
        step();
        rst = 1'b0;
        step();
        res_valid = 1'b1; res_rec = tbl[0].rec; res_flags = 5'b00000;
        sbq.push_back({32'h3F800000, 5'b00000, 16'd0});
        step();
        res_valid = 1'b0;
        chk("post_rst_proto", {63'd0, proto_err}, 64'd1);
        chk("post_rst_cycles", {48'd0, out_cycles}, 64'd0);
        drain(1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/sqrt_result_collector.md
SQRT_RESULT_COLLECTOR -- requirements
Module: sqrt_result_collector

Interface
REQ-001 SHALL have parameter EXP_WIDTH, default 8, exponent width.
REQ-002 SHALL have parameter SIG_WIDTH, default 24, significand width incl. hidden bit; FW = EXP_WIDTH+SIG_WIDTH.
REQ-003 SHALL have parameter DEPTH, default 4, result FIFO entries, power of two, >= 2.
REQ-004 SHALL have port clk_i  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port issue_i  input  1  operand accepted by the divSqrtRecFN_small unit this cycle (inValid & inReady).
REQ-007 SHALL have port res_valid_i  input  1  unit outValid; single-cycle pulse, no backpressure.
REQ-008 SHALL have port res_rec_i  input  FW+1  unit result, recoded format.
REQ-009 SHALL have port res_flags_i  input  5  unit exceptionFlags.
REQ-010 SHALL have port out_valid_o  output  1  FIFO head valid.
REQ-011 SHALL have port out_ready_i  input  1  downstream accepts head.
REQ-012 SHALL have port out_data_o  output  FW  head result, standard IEEE format.
REQ-013 SHALL have port out_flags_o  output  5  head exception flags.
REQ-014 SHALL have port out_cycles_o  output  16  head issue-to-result latency.
REQ-015 SHALL have port count_o  output  log2(DEPTH)+1  FIFO occupancy.
REQ-016 SHALL have port overflow_o  output  1  sticky: result dropped because FIFO full.
REQ-017 SHALL have port proto_err_o  output  1  sticky: issue while busy, or result while idle.

Function
REQ-018 SHALL convert res_rec_i to standard format via one recFNToFN instance before storage; stored entry = {data, flags, cycles}.
REQ-019 SHALL track state IDLE/BUSY: IDLE->BUSY on issue_i; BUSY->IDLE on res_valid_i without issue_i; BUSY stays BUSY on res_valid_i with issue_i (back-to-back).
REQ-020 SHALL count latency: counter loads 0 on cycle of issue_i, increments each BUSY cycle, saturates at 0xFFFF; issue_i at edge T, res_valid_i at edge T+N stores cycles = N.
REQ-021 SHALL on issue_i while BUSY and no res_valid_i set proto_err_o and restart counter at 0.
REQ-022 SHALL on res_valid_i while IDLE set proto_err_o and store entry with cycles = 0.
REQ-023 SHALL push on res_valid_i when count_o < DEPTH, or when count_o = DEPTH and pop occurs same cycle.
REQ-024 SHALL pop when out_valid_o & out_ready_i; out_valid_o = (count_o != 0); head outputs stable while out_valid_o & !out_ready_i.
REQ-025 SHALL on res_valid_i with FIFO full and no pop drop the result, set overflow_o, leave contents unchanged.
REQ-026 SHALL on simultaneous push and pop keep count_o unchanged and preserve order.
REQ-027 SHALL wrap read/write pointers modulo DEPTH.
REQ-028 SHALL present head combinationally from storage (no extra latency); pushed entry visible at out_*_o the cycle after res_valid_i.
REQ-029 SHALL hold overflow_o and proto_err_o set until reset.

Reset
REQ-030 SHALL on rst_i assertion, immediately and regardless of clock: state IDLE, counter 0, pointers 0, count_o 0, out_valid_o 0, overflow_o 0, proto_err_o 0, out_data_o/out_flags_o/out_cycles_o 0.
REQ-031 SHALL discard in-flight latency and FIFO contents on reset mid-operation; a res_valid_i after release with no issue_i sets proto_err_o.

Verification
REQ-032 SHALL pass: issue_i (sqrt of 0x41400000), res_valid_i 23 cycles later with recoded 0x405db3d7, flags 0 -> out_data_o 0x405db3d7, out_cycles_o 23, count_o 1.
REQ-033 SHALL pass: DEPTH=4, out_ready_i=0, five issue/result pairs -> count_o 4, overflow_o 1, popped order = first four results.
REQ-034 SHALL pass: FIFO full, res_valid_i with out_ready_i=1 same cycle -> count_o stays 4, overflow_o 0, new result is last popped.
REQ-035 SHALL pass: res_valid_i with no prior issue_i, recoded NaN, flags 5'b10000 -> proto_err_o 1, out_cycles_o 0, out_flags_o 5'b10000, out_data_o NaN.
REQ-036 SHALL pass: issue_i, rst_i asserted 10 cycles later between clock edges -> all outputs 0 before next edge; later result -> proto_err_o 1.
